// File: rtl/mips32_reg_dump_pkg.sv
// Shared definitions for the pipe_MIPS32 register-dump port: default sizes,
// the HLT opcode and the dump sequencer state encoding.
package mips32_reg_dump_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int IDX_W_DEF    = 5;

    // pipe_MIPS32 HLT opcode; its retirement raises the CPU HALTED level.
    localparam logic [5:0] OP_HLT = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_READ  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    // States in which a falling halted cancels the dump.
    function automatic logic is_active(input state_t s);
        return (s == ST_READ) || (s == ST_HOLD) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/mips32_reg_dump.sv
// Post-halt register-file dump for pipe_MIPS32.
// Walks register indices 0..NUM_REGS-1 through a combinational read port and
// streams each value over a valid/ready interface.
// Optional feature: define REG_DUMP_CSUM_EN to append one XOR-checksum beat.
//
// Handshake: a beat transfers on a rising clk1 edge where dump_valid and
// dump_ready are both high; while dump_valid is high and no transfer has
// happened, dump_data/dump_idx/dump_last do not change. The only way a
// presented beat is withdrawn is a cancel (halted falling, or rst).
module mips32_reg_dump
    import mips32_reg_dump_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int IDX_W    = IDX_W_DEF
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              halted,
    input  logic              start,
    output logic [IDX_W-1:0]  rf_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [IDX_W-1:0]  dump_idx,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t            state;
    state_t            state_n;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_n;
    logic              halted_q;
    logic              valid_n;
    logic [DATA_W-1:0] data_n;
    logic [IDX_W-1:0]  didx_n;
    logic              last_n;
    logic              done_n;
    logic              aborted_n;
    logic              trigger_rise;
`ifdef REG_DUMP_CSUM_EN
    logic [DATA_W-1:0] csum;
    logic [DATA_W-1:0] csum_n;
`endif

    assign trigger_rise = halted & ~halted_q;

    // The register file is read with the current index; the value is
    // captured at the end of the READ cycle.
    assign rf_addr = idx;
    assign busy    = (state != ST_IDLE);

    // State, index, output beat and status pulse registers.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            halted_q   <= 1'b0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_idx   <= '0;
            dump_last  <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
`ifdef REG_DUMP_CSUM_EN
            csum       <= '0;
`endif
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            halted_q   <= halted;
            dump_valid <= valid_n;
            dump_data  <= data_n;
            dump_idx   <= didx_n;
            dump_last  <= last_n;
            done       <= done_n;
            aborted    <= aborted_n;
`ifdef REG_DUMP_CSUM_EN
            csum       <= csum_n;
`endif
        end
    end

    // Next-state and next-beat logic; cancel on halted falling has priority.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        valid_n   = dump_valid;
        data_n    = dump_data;
        didx_n    = dump_idx;
        last_n    = dump_last;
        done_n    = 1'b0;
        aborted_n = 1'b0;
`ifdef REG_DUMP_CSUM_EN
        csum_n    = csum;
`endif

        if (is_active(state) && !halted) begin
            // Partial beat is dropped and never offered again.
            state_n   = ST_IDLE;
            valid_n   = 1'b0;
            last_n    = 1'b0;
            aborted_n = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trigger_rise || (start && halted)) begin
                        state_n = ST_READ;
                        idx_n   = '0;
`ifdef REG_DUMP_CSUM_EN
                        csum_n  = '0;
`endif
                    end else if (start) begin
                        state_n = ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    if (halted) begin
                        state_n = ST_READ;
                        idx_n   = '0;
`ifdef REG_DUMP_CSUM_EN
                        csum_n  = '0;
`endif
                    end
                end

                ST_READ: begin
                    data_n  = rf_rdata;
                    didx_n  = idx;
                    valid_n = 1'b1;
`ifdef REG_DUMP_CSUM_EN
                    last_n  = 1'b0;
`else
                    last_n  = (idx == LAST_IDX);
`endif
                    state_n = ST_HOLD;
                end

                ST_HOLD: begin
                    if (dump_ready) begin
                        valid_n = 1'b0;
                        last_n  = 1'b0;
`ifdef REG_DUMP_CSUM_EN
                        csum_n  = csum ^ dump_data;
`endif
                        if (idx == LAST_IDX) begin
`ifdef REG_DUMP_CSUM_EN
                            state_n = ST_CSUM;
`else
                            state_n = ST_FIN;
                            done_n  = 1'b1;
`endif
                        end else begin
                            idx_n   = idx + IDX_W'(1);
                            state_n = ST_READ;
                        end
                    end
                end

`ifdef REG_DUMP_CSUM_EN
                ST_CSUM: begin
                    // First cycle loads the checksum beat, then it is held
                    // until accepted.
                    if (!dump_valid) begin
                        data_n  = csum;
                        didx_n  = '0;
                        last_n  = 1'b1;
                        valid_n = 1'b1;
                    end else if (dump_ready) begin
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        state_n = ST_FIN;
                        done_n  = 1'b1;
                    end
                end
`endif

                ST_FIN: begin
                    if (trigger_rise) begin
                        state_n = ST_READ;
                        idx_n   = '0;
`ifdef REG_DUMP_CSUM_EN
                        csum_n  = '0;
`endif
                    end else begin
                        state_n = ST_IDLE;
                    end
                end

                default: begin
                    state_n = ST_IDLE;
                    valid_n = 1'b0;
                    last_n  = 1'b0;
                end
            endcase
        end
    end

endmodule
